// File: rtl/div_sweep_ctrl_if.sv
// rtl/div_sweep_ctrl_if.sv - config handshake and divider-ratio output bundle for div_sweep_ctrl
interface div_sweep_ctrl_if #(
    parameter int DIV_W   = 6,
    parameter int DWELL_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [DIV_W-1:0]   cfg_start;
    logic [DIV_W-1:0]   cfg_stop;
    logic [DIV_W-1:0]   cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic [1:0]         cfg_mode;
    logic               abort;
    logic [DIV_W-1:0]   div_out;
    logic               div_update;
    logic               busy;
    logic               done;

    modport master (
        output cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode, abort,
        input  cfg_ready, div_out, div_update, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_start, cfg_stop, cfg_step, cfg_dwell, cfg_mode, abort,
        output cfg_ready, div_out, div_update, busy, done
    );
endinterface

// File: rtl/div_sweep_ctrl.sv
// rtl/div_sweep_ctrl.sv - steps the clock-divider ratio between two endpoints with a programmable dwell
module div_sweep_ctrl #(
    parameter int DIV_W       = 6,
    parameter int DWELL_W     = 8,
    parameter int DIV_DEFAULT = 8
) (
    input  logic             clkin,
    input  logic             rst,
    div_sweep_ctrl_if.slave  bus
);
    localparam logic [DIV_W-1:0] RATIO_DEF = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] RATIO_MIN = DIV_W'(2);
    localparam logic [DIV_W-1:0] STEP_MIN  = DIV_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   cur_q, cur_d;
    logic [DIV_W-1:0]   start_q, start_d;
    logic [DIV_W-1:0]   stop_q, stop_d;
    logic [DIV_W-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic               up_q, up_d;
    logic               tgt_stop_q, tgt_stop_d;
    logic               upd_q, upd_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;

    logic               accept;
    logic [DIV_W-1:0]   start_san, stop_san, step_san;
    logic [DIV_W-1:0]   target, tri_target;
    logic               dir_up;
    logic [DIV_W-1:0]   fwd_next, tri_next;

    // One step from cur toward tgt; the extra bit keeps overshoot visible so it clamps instead of wrapping.
    function automatic logic [DIV_W-1:0] step_toward(input logic [DIV_W-1:0] cur,
                                                     input logic [DIV_W-1:0] tgt,
                                                     input logic [DIV_W-1:0] stp,
                                                     input logic             up);
        logic [DIV_W:0] sum;
        logic [DIV_W-1:0] res;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, stp};
            res = (sum >= {1'b0, tgt}) ? tgt : sum[DIV_W-1:0];
        end else begin
            sum = {1'b0, cur} - {1'b0, stp};
            res = (sum[DIV_W] || (sum[DIV_W-1:0] <= tgt)) ? tgt : sum[DIV_W-1:0];
        end
        return res;
    endfunction

    assign accept    = bus.cfg_valid & ready_q & ~bus.abort;
    assign start_san = (bus.cfg_start < RATIO_MIN) ? RATIO_MIN : bus.cfg_start;
    assign stop_san  = (bus.cfg_stop  < RATIO_MIN) ? RATIO_MIN : bus.cfg_stop;
    assign step_san  = (bus.cfg_step  < STEP_MIN)  ? STEP_MIN  : bus.cfg_step;

    // up_q is the start->stop direction; heading back to start runs the other way.
    assign target     = tgt_stop_q ? stop_q : start_q;
    assign tri_target = tgt_stop_q ? start_q : stop_q;
    assign dir_up     = tgt_stop_q ? up_q : ~up_q;
    assign fwd_next   = step_toward(cur_q, target, step_q, dir_up);
    assign tri_next   = step_toward(cur_q, tri_target, step_q, ~dir_up);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cur_q      <= RATIO_DEF;
            start_q    <= RATIO_MIN;
            stop_q     <= RATIO_MIN;
            step_q     <= STEP_MIN;
            dwell_q    <= '0;
            cnt_q      <= '0;
            mode_q     <= 2'b00;
            up_q       <= 1'b1;
            tgt_stop_q <= 1'b1;
            upd_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            step_q     <= step_d;
            dwell_q    <= dwell_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            up_q       <= up_d;
            tgt_stop_q <= tgt_stop_d;
            upd_q      <= upd_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        start_d    = start_q;
        stop_d     = stop_q;
        step_d     = step_q;
        dwell_d    = dwell_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        up_d       = up_q;
        tgt_stop_d = tgt_stop_q;
        upd_d      = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    state_d    = RUN;
                    start_d    = start_san;
                    stop_d     = stop_san;
                    step_d     = step_san;
                    dwell_d    = bus.cfg_dwell;
                    mode_d     = bus.cfg_mode;
                    up_d       = (start_san <= stop_san);
                    tgt_stop_d = 1'b1;
                    cur_d      = start_san;
                    cnt_d      = bus.cfg_dwell;
                    upd_d      = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (cur_q != target) begin
                    cur_d = fwd_next;
                    cnt_d = dwell_q;
                    upd_d = 1'b1;
                end else begin
                    case (mode_q)
                        2'b01: begin
                            cur_d = start_q;
                            cnt_d = dwell_q;
                            upd_d = 1'b1;
                        end
                        2'b10: begin
                            tgt_stop_d = ~tgt_stop_q;
                            cur_d      = tri_next;
                            cnt_d      = dwell_q;
                            upd_d      = 1'b1;
                        end
                        default: begin
                            state_d = HOLD;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d == RUN);
        ready_d = (state_d != RUN);
    end

    assign bus.cfg_ready  = ready_q;
    assign bus.div_out    = cur_q;
    assign bus.div_update = upd_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_div_sweep_ctrl.sv
// tb/tb_div_sweep_ctrl.sv - scoreboard bench for div_sweep_ctrl
module tb_div_sweep_ctrl;
    logic clkin = 1'b0;
    logic rst   = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        bit         is_done;
        logic [5:0] val;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    div_sweep_ctrl_if #(.DIV_W(6), .DWELL_W(8)) bus ();

    div_sweep_ctrl #(.DIV_W(6), .DWELL_W(8), .DIV_DEFAULT(8)) dut (
        .clkin (clkin),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input bit is_done, input int val, input int c);
        exp_t e;
        e.is_done = is_done;
        e.val     = 6'(val);
        e.cyc     = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        int n = 0;
        @(negedge clkin);
        while (cyc < c) begin
            if (n > 500) begin
                check("wait_timeout", 32'(cyc), 32'(c));
                break;
            end
            @(negedge clkin);
            n++;
        end
    endtask

    task automatic send_cfg(input int s, input int p, input int st, input int dw, input int md,
                            output int a);
        @(negedge clkin);
        check("cfg_ready_before_send", 32'(bus.cfg_ready), 32'd1);
        bus.cfg_start = 6'(s);
        bus.cfg_stop  = 6'(p);
        bus.cfg_step  = 6'(st);
        bus.cfg_dwell = 8'(dw);
        bus.cfg_mode  = 2'(md);
        bus.cfg_valid = 1'b1;
        @(posedge clkin);
        #1;
        a = cyc;
        bus.cfg_valid = 1'b0;
    endtask

    // Monitor: every update or done pulse must match the head of the expected queue, including its cycle.
    always @(negedge clkin) begin
        if (!rst && (bus.div_update || bus.done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc %0d upd %0b done %0b div %0d", cyc,
                         bus.div_update, bus.done, bus.div_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.done !== mon_e.is_done || bus.div_update !== !mon_e.is_done ||
                    bus.div_out !== mon_e.val || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL event: got cyc %0d upd %0b done %0b div %0d, want cyc %0d done %0b div %0d",
                             cyc, bus.div_update, bus.done, bus.div_out, mon_e.cyc, mon_e.is_done, mon_e.val);
                end
            end
        end
    end

    initial begin
        int a;
        int tri_v[7] = '{4, 6, 8, 6, 4, 6, 8};
        int rep_v[6] = '{4, 6, 8, 4, 6, 8};

        bus.cfg_valid = 1'b0;
        bus.cfg_start = '0;
        bus.cfg_stop  = '0;
        bus.cfg_step  = '0;
        bus.cfg_dwell = '0;
        bus.cfg_mode  = '0;
        bus.abort     = 1'b0;

        repeat (3) @(negedge clkin);
        check("reset_div_out", 32'(bus.div_out), 32'd8);
        check("reset_update", 32'(bus.div_update), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_ready", 32'(bus.cfg_ready), 32'd1);
        rst = 1'b0;

        // single sweep up with dwell 2
        send_cfg(4, 10, 3, 2, 0, a);
        push(0, 4, a); push(0, 7, a + 3); push(0, 10, a + 6); push(1, 10, a + 9);
        wait_cyc(a + 9);
        check("single_busy_after_done", 32'(bus.busy), 32'd0);
        check("single_ready_after_done", 32'(bus.cfg_ready), 32'd1);
        wait_cyc(a + 10);
        check("single_drain", 32'(exp_q.size()), 32'd0);

        // down sweep with clamp on the last step, then restart from HOLD going up
        send_cfg(20, 9, 5, 0, 0, a);
        push(0, 20, a); push(0, 15, a + 1); push(0, 10, a + 2); push(0, 9, a + 3); push(1, 9, a + 4);
        wait_cyc(a + 5);
        check("down_drain", 32'(exp_q.size()), 32'd0);
        send_cfg(2, 9, 4, 0, 0, a);
        push(0, 2, a); push(0, 6, a + 1); push(0, 9, a + 2); push(1, 9, a + 3);
        wait_cyc(a + 4);
        check("up_clamp_drain", 32'(exp_q.size()), 32'd0);

        // triangle, then abort coinciding with a dwell-0 expiry
        send_cfg(4, 8, 2, 0, 2, a);
        for (int i = 0; i < 7; i++) push(0, tri_v[i], a + i);
        wait_cyc(a + 6);
        bus.abort = 1'b1;
        @(posedge clkin);
        #1;
        bus.abort = 1'b0;
        wait_cyc(a + 8);
        check("tri_abort_busy", 32'(bus.busy), 32'd0);
        check("tri_abort_div_out", 32'(bus.div_out), 32'd8);
        check("tri_abort_ready", 32'(bus.cfg_ready), 32'd1);
        check("tri_drain", 32'(exp_q.size()), 32'd0);

        // repeat (sawtooth)
        send_cfg(4, 8, 2, 0, 1, a);
        for (int i = 0; i < 6; i++) push(0, rep_v[i], a + i);
        wait_cyc(a + 5);
        bus.abort = 1'b1;
        @(posedge clkin);
        #1;
        bus.abort = 1'b0;
        wait_cyc(a + 7);
        check("rep_abort_busy", 32'(bus.busy), 32'd0);
        check("rep_abort_div_out", 32'(bus.div_out), 32'd8);
        check("rep_drain", 32'(exp_q.size()), 32'd0);

        // sanitised endpoints/step; a config offered during RUN must be refused
        send_cfg(0, 1, 0, 1, 0, a);
        push(0, 2, a); push(1, 2, a + 2);
        @(negedge clkin);
        check("run_ready_low", 32'(bus.cfg_ready), 32'd0);
        check("run_busy_high", 32'(bus.busy), 32'd1);
        bus.cfg_start = 6'd30;
        bus.cfg_stop  = 6'd40;
        bus.cfg_valid = 1'b1;
        @(negedge clkin);
        bus.cfg_valid = 1'b0;
        wait_cyc(a + 3);
        check("sanitise_div_out", 32'(bus.div_out), 32'd2);
        check("sanitise_drain", 32'(exp_q.size()), 32'd0);

        // abort together with cfg_valid in an idle state blocks acceptance
        @(negedge clkin);
        bus.abort     = 1'b1;
        bus.cfg_start = 6'd5;
        bus.cfg_stop  = 6'd9;
        bus.cfg_valid = 1'b1;
        @(posedge clkin);
        #1;
        bus.abort     = 1'b0;
        bus.cfg_valid = 1'b0;
        @(negedge clkin);
        check("abort_accept_busy", 32'(bus.busy), 32'd0);
        check("abort_accept_update", 32'(bus.div_update), 32'd0);
        check("abort_accept_ready", 32'(bus.cfg_ready), 32'd1);

        // asynchronous reset in the middle of a long sweep
        send_cfg(4, 60, 1, 5, 0, a);
        push(0, 4, a);
        wait_cyc(a + 2);
        #1;
        rst = 1'b1;
        #1;
        check("rst_div_out", 32'(bus.div_out), 32'd8);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", 32'(bus.cfg_ready), 32'd1);
        check("rst_update", 32'(bus.div_update), 32'd0);
        check("rst_drain", 32'(exp_q.size()), 32'd0);
        @(negedge clkin);
        rst = 1'b0;

        send_cfg(4, 10, 3, 2, 0, a);
        push(0, 4, a); push(0, 7, a + 3); push(0, 10, a + 6); push(1, 10, a + 9);
        wait_cyc(a + 10);
        check("post_rst_drain", 32'(exp_q.size()), 32'd0);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_sweep_ctrl.md
Name: div_sweep_ctrl

Overview:
- Sequencer that drives the divide-ratio input of the programmable clock divider to produce frequency sweeps for the function generator.
- Software/host loads a sweep description through a valid/ready config port: start ratio, stop ratio, step, dwell and mode.
- The block then steps div_out between the endpoints, holding each value for a programmed number of clkin cycles.
- It flags every ratio change and signals sweep completion.

Parameters:
- DIV_W, 6, width of divide ratio (matches divider div input)
- DWELL_W, 8, width of dwell counter
- DIV_DEFAULT, 8, div_out value after reset

Ports:
- clkin  in  1  system clock (same clock as divider)
- rst  in  1  reset
- cfg_valid  in  1  config offered
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_start  in  DIV_W  first ratio
- cfg_stop  in  DIV_W  end ratio
- cfg_step  in  DIV_W  step magnitude
- cfg_dwell  in  DWELL_W  hold time per value, in cycles minus one
- cfg_mode  in  2  00 single, 01 repeat (sawtooth), 10 triangle, 11 = single
- abort  in  1  stop running sweep
- div_out  out  DIV_W  ratio to divider
- div_update  out  1  one-cycle pulse, high in the cycle div_out takes a new (or rewritten) value
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse at natural end of single sweep

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clkin. All outputs are registered.
- Reset values: state IDLE, div_out=DIV_DEFAULT, div_update=0, busy=0, done=0, cfg_ready=1.
- States: IDLE, RUN, HOLD. cfg_ready=1 in IDLE and HOLD, 0 in RUN.
- Accept: cfg_valid & cfg_ready & ~abort. All cfg_* fields are latched on accept.
- Cycle after accept:
  - state=RUN, busy=1.
  - div_out=start', div_update=1.
  - Dwell counter loaded with dwell.
- Sanitisation at accept:
  - start' = max(start,2), stop' = max(stop,2); ratios below 2 are illegal for the divider.
  - step' = max(step,1).
- Direction: up if start' <= stop', else down.
- Target: initially stop'.
- RUN: the counter decrements each cycle. In the cycle it is 0:
  - If cur != target: next = cur ± step', clamped to target if it would pass it. div_out=next, div_update=1, counter reloaded.
  - If cur == target and mode single (or 11): state HOLD, done=1 for one cycle, busy=0, div_out unchanged, no div_update.
  - If cur == target and mode repeat: div_out=start', div_update=1, counter reloaded.
  - If cur == target and mode triangle: swap target between start' and stop', reverse direction, then apply one step toward the new target (clamped). div_update=1, counter reloaded.
- Hold time: each value is held exactly dwell+1 cycles, measured between consecutive div_update pulses.
- start'==stop':
  - single: done after the first dwell.
  - repeat and triangle: div_out stays constant, with div_update pulsing every dwell+1 cycles.
- Arithmetic: the add/subtract is done at DIV_W+1 bits before clamping, so there is no wrap-around.
- Abort in RUN: next cycle state IDLE, busy=0, div_out holds its current value, no done, no div_update. Abort has priority over a counter expiry in the same cycle. Abort in IDLE/HOLD is ignored but blocks acceptance in that cycle.
- HOLD behaves as IDLE for acceptance. A new config restarts from start'.
- Reset mid-sweep: all outputs return to reset values immediately (asynchronous).

Test Plan:
- Single up: start=4, stop=10, step=3, dwell=2, mode=00, accepted at T -> div_out 4@T+1, 7@T+4, 10@T+7; done pulse @T+10; div_update exactly 3 pulses; busy 0 and cfg_ready 1 from T+10.
- Clamp/down: start=20, stop=9, step=5, dwell=0 -> 20, 15, 10, 9 on consecutive cycles, then done; second run start=2, stop=9, step=4 -> 2, 6, 9.
- Triangle: start=4, stop=8, step=2, dwell=0, mode=10 -> 4, 6, 8, 6, 4, 6, 8 … with div_update every cycle and no done; repeat mode same config -> 4, 6, 8, 4, 6, 8 ….
- Sanitise: start=0, stop=1, step=0, dwell=1, mode=00 -> div_out=2 with one div_update, done after 2 cycles; cfg_valid during RUN -> cfg_ready=0, no accept.
- Abort/simultaneity: abort in the same cycle as counter expiry in RUN -> IDLE, div_out unchanged, no done/div_update. abort together with cfg_valid in IDLE -> not accepted.
- Reset mid-sweep: rst asserted during RUN -> div_out=8, busy=0, cfg_ready=1 asynchronously. After release, the next config runs normally.
